reminder_scheduler: RTL
=======================

# reminder_scheduler

Controller that sequences the water-tracking datapath. It generates the interval timebase that the drink-detection datapath consumes as `count`. At every interval end it evaluates that datapath's `drank` flag, and runs a reminder/snooze/escalation state machine that drives the user-facing LED and buzzer. It sits between the drink-detection datapath and the board I/O (acknowledge button, LED, buzzer).

## Interface
- `TICKS_PER_INTERVAL`, 1800 — clock cycles per interval (30 min at 1 Hz); legal range 2..65536.
- `SNOOZE_TICKS`, 300 — clock cycles a snooze lasts; legal range ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `drank`  in  1  datapath flag: a drink occurred in the current interval (datapath clears it while `count == 0`).
- `ack`  in  1  user acknowledge; single-cycle pulse, already debounced and synchronised.
- `count`  out  16  interval timer, drives the datapath `count` input.
- `interval_end`  out  1  one-cycle strobe, high while `count == TICKS_PER_INTERVAL-1`.
- `remind`  out  1  reminder LED.
- `buzz`  out  1  buzzer enable.
- `esc_level`  out  2  consecutive-miss escalation level, 0..3.
- `missed`  out  8  saturating count of intervals that ended without a drink.

## Operation
- Timer: `count` increments every cycle and wraps from `TICKS_PER_INTERVAL-1` to 0. `interval_end` is combinational from `count`.
- "Miss" means `interval_end` is high and `drank` is 0 in the same cycle.
- FSM states: IDLE, REMIND, SNOOZE.
- IDLE: on a miss, go to REMIND and set `esc_level` to 1.
- REMIND:
  - `drank` = 1 → IDLE.
  - else a miss → stay in REMIND, increment `esc_level`.
  - else `ack` → SNOOZE, load snooze counter with `SNOOZE_TICKS-1`.
- SNOOZE:
  - `drank` = 1 → IDLE.
  - else a miss → REMIND, increment `esc_level`.
  - else snooze counter == 0 → REMIND, increment `esc_level`.
  - else decrement the snooze counter.
- `esc_level` saturates at 3 and clears to 0 on any transition into IDLE.
- Priority when events coincide: `drank` > miss > snooze expiry > `ack`.
- `ack` has no effect in IDLE or SNOOZE.
- `missed` increments on every miss in any state and saturates at 255. Only reset clears it.
- Outputs are Moore/registered:
  - `remind` = (state == REMIND).
  - `buzz` = (state == REMIND) && (`esc_level` ≥ 2).

## Timing
- Reset values: `count` = 0, state IDLE, `esc_level` = 0, `missed` = 0, `remind` = 0, `buzz` = 0, snooze counter = 0. `interval_end` is 0 unless `TICKS_PER_INTERVAL` = 1, which is illegal.
- Miss at cycle N → `remind` and new `esc_level` visible at cycle N+1.
- `ack` at cycle N in REMIND → `remind` low at N+1. SNOOZE lasts exactly `SNOOZE_TICKS` cycles. `remind` returns high at N+1+`SNOOZE_TICKS` unless a higher-priority event intervenes.
- `drank` is sampled every cycle; exit to IDLE takes effect the next cycle.
- Asserting `reset_n` low mid-interval or mid-snooze returns every register to its reset value immediately. `count` restarts from 0 after release.
- `count` is zero-extended to 16 bits. Width rules:
  - timer internal width is $clog2(`TICKS_PER_INTERVAL`);
  - snooze counter width is $clog2(`SNOOZE_TICKS`+1).

## Configuration
- `REMINDER_SNOOZE_EN` defined: SNOOZE state and snooze counter are present, behaving as above.
- `REMINDER_SNOOZE_EN` undefined:
  - SNOOZE and the snooze counter are removed.
  - `ack` in REMIND → IDLE and clears `esc_level`.
  - `SNOOZE_TICKS` is unused.
  - All other behaviour is identical.

## Structure
- Shared `water_pkg`:
  - `reminder_state_t` enum (IDLE, REMIND, SNOOZE);
  - `ESC_MAX` = 3;
  - `MISSED_MAX` = 255;
  - `COUNT_W` = 16.
- Sub-module `interval_timer`: mod-N counter producing `count` and `interval_end`, parameterised by N. It is reusable by other timebase consumers.
- FSM, escalation counter, missed counter and snooze counter stay in `reminder_scheduler`.

## Test plan
Bench parameters: `TICKS_PER_INTERVAL` = 8, `SNOOZE_TICKS` = 3.
- `drank` held 0 from reset → `interval_end` at cycle 7; `remind` = 1 and `esc_level` = 1 at cycle 8; `missed` = 1; `buzz` = 0.
- Continue with no drink or ack for three more intervals → `esc_level` = 2 at cycle 16 (`buzz` = 1), then 3, and stays 3; `missed` = 4.
- In REMIND, pulse `ack` at cycle 10 → `remind` = 0 on cycles 11–13, `remind` = 1 at cycle 14, `esc_level` + 1. Without `REMINDER_SNOOZE_EN`: IDLE at 11, `esc_level` = 0.
- In SNOOZE, assert `drank` = 1 → IDLE next cycle, `esc_level` = 0, `remind` stays 0; `missed` unchanged.
- Same-cycle `ack` and `drank` in REMIND → IDLE, not SNOOZE. Miss coinciding with `ack` → stays REMIND, `esc_level` + 1.
- Pull `reset_n` low at `count` = 5 during SNOOZE → all outputs zero immediately; after release, `count` counts 0..7 and the first miss occurs 8 cycles later.

Source files
------------

// File: rtl/water_pkg.sv
// Shared types and limits for the water-tracking reminder path.
// Latency: n/a (declarations only). Backpressure: n/a.
package water_pkg;
    typedef enum logic [1:0] {IDLE, REMIND, SNOOZE} reminder_state_t;

    localparam int         COUNT_W    = 16;
    localparam logic [1:0] ESC_MAX    = 2'd3;
    localparam logic [7:0] MISSED_MAX = 8'd255;

    // Escalation step that holds at the top level.
    function automatic logic [1:0] esc_inc(input logic [1:0] e);
        return (e == ESC_MAX) ? e : e + 2'd1;
    endfunction
endpackage

// File: rtl/reminder_scheduler_if.sv
// Datapath/board-side signal bundle of the reminder scheduler.
// Latency: n/a (wiring only). Backpressure: none, all signals are level/strobe.
interface reminder_scheduler_if;
    import water_pkg::*;

    logic               drank;
    logic               ack;
    logic [COUNT_W-1:0] count;
    logic               interval_end;
    logic               remind;
    logic               buzz;
    logic [1:0]         esc_level;
    logic [7:0]         missed;

    modport master (output drank, ack,
                    input  count, interval_end, remind, buzz, esc_level, missed);
    modport slave  (input  drank, ack,
                    output count, interval_end, remind, buzz, esc_level, missed);
endinterface

// File: rtl/interval_timer.sv
// Mod-N free-running timebase with an end-of-period strobe.
// Latency: interval_end is combinational from count. Backpressure: none, always counts.
module interval_timer
    import water_pkg::*;
#(
    parameter int N = 1800
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [COUNT_W-1:0] count,
    output logic               interval_end
);
    localparam int         W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt;

    assign interval_end = (cnt == LAST);
    assign count        = COUNT_W'(cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= interval_end ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/reminder_scheduler.sv
// Interval timebase plus reminder/snooze/escalation FSM driving LED and buzzer; REMINDER_SNOOZE_EN enables snooze.
// Latency: registered outputs change one cycle after the causing miss/drank/ack. Backpressure: none.
module reminder_scheduler
    import water_pkg::*;
#(
    parameter int TICKS_PER_INTERVAL = 1800,
    parameter int SNOOZE_TICKS       = 300
) (
    input  logic                 clk,
    input  logic                 reset_n,
    reminder_scheduler_if.slave  bus
);
    if (TICKS_PER_INTERVAL < 2 || TICKS_PER_INTERVAL > 65536) begin : g_bad_ticks
        $error("TICKS_PER_INTERVAL out of range 2..65536");
    end
    if (SNOOZE_TICKS < 1) begin : g_bad_snooze
        $error("SNOOZE_TICKS must be at least 1");
    end

    logic [COUNT_W-1:0] count;
    logic               interval_end;
    logic               miss;
    reminder_state_t    state;
    logic [1:0]         esc;
    logic [7:0]         missed;
    logic               remind;
    logic               buzz;

    interval_timer #(.N(TICKS_PER_INTERVAL)) u_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .count        (count),
        .interval_end (interval_end)
    );

    assign miss             = interval_end & ~bus.drank;
    assign bus.count        = count;
    assign bus.interval_end = interval_end;
    assign bus.remind       = remind;
    assign bus.buzz         = buzz;
    assign bus.esc_level    = esc;
    assign bus.missed       = missed;

`ifdef REMINDER_SNOOZE_EN
    localparam int SW = $clog2(SNOOZE_TICKS + 1);
    logic [SW-1:0] snz;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            esc    <= '0;
            missed <= '0;
            remind <= 1'b0;
            buzz   <= 1'b0;
`ifdef REMINDER_SNOOZE_EN
            snz    <= '0;
`endif
        end else begin
            // Miss counting is independent of the FSM state.
            if (miss && missed != MISSED_MAX) begin
                missed <= missed + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (miss) begin
                        state  <= REMIND;
                        esc    <= 2'd1;
                        remind <= 1'b1;
                        buzz   <= 1'b0;
                    end
                end
                REMIND: begin
                    if (bus.drank) begin
                        state  <= IDLE;
                        esc    <= '0;
                        remind <= 1'b0;
                        buzz   <= 1'b0;
                    end else if (miss) begin
                        esc    <= esc_inc(esc);
                        buzz   <= (esc_inc(esc) >= 2'd2);
                    end else if (bus.ack) begin
`ifdef REMINDER_SNOOZE_EN
                        state  <= SNOOZE;
                        snz    <= SW'(SNOOZE_TICKS - 1);
`else
                        state  <= IDLE;
                        esc    <= '0;
`endif
                        remind <= 1'b0;
                        buzz   <= 1'b0;
                    end
                end
`ifdef REMINDER_SNOOZE_EN
                SNOOZE: begin
                    if (bus.drank) begin
                        state  <= IDLE;
                        esc    <= '0;
                        remind <= 1'b0;
                        buzz   <= 1'b0;
                    end else if (miss || snz == '0) begin
                        state  <= REMIND;
                        esc    <= esc_inc(esc);
                        remind <= 1'b1;
                        buzz   <= (esc_inc(esc) >= 2'd2);
                    end else begin
                        snz    <= snz - SW'(1);
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    esc    <= '0;
                    remind <= 1'b0;
                    buzz   <= 1'b0;
                end
            endcase
        end
    end
endmodule
